// File: rtl/stream_mux_n_to_1.sv
// rtl/stream_mux_n_to_1.sv - N-to-1 stream multiplexer with fixed/round-robin select and registered output
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode                0 = fixed select via sel, 1 = round-robin
//   sel [SW]            channel index used in fixed mode (>= N never grants)
//   in_data [N*W]       channel k at bits [k*W +: W]
//   in_valid/in_ready   per-channel handshake, at most one ready bit high
//   out_data/out_ch     registered beat and the channel it came from
//   out_valid/out_ready downstream handshake
module stream_mux_n_to_1 #(
  parameter int N = 7,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  // Valid vector padded to the full select range so any sel value indexes
  // a real bit; the padding is zero, so out-of-range selects never grant.
  localparam int NP = 1 << SW;

  logic [NP-1:0] valid_ext;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_grant;
  logic          rr_found;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic [W-1:0]  grant_data;
  logic          load_en;

  assign valid_ext = NP'(in_valid);

  // Round-robin search starts just after the last served channel.
  always_comb begin
    int cand;
    cand     = 0;
    rr_found = 1'b0;
    rr_grant = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!rr_found && valid_ext[cand[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_grant = cand[SW-1:0];
      end
    end
  end

  assign grant       = mode ? rr_grant : sel;
  assign grant_valid = mode ? rr_found : valid_ext[sel];
  assign load_en     = !out_valid || out_ready;

  assign in_ready = (load_en && grant_valid) ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(grant) == k) grant_data = in_data[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SW'(N - 1);
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        rr_ptr    <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// tb/tb_stream_mux_n_to_1.sv - scoreboard bench for stream_mux_n_to_1
module tb_stream_mux_n_to_1;

  localparam int N  = 7;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [W-1:0]  data;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  stream_mux_n_to_1 #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k + 8'h10);
  endtask

  // Reference model: evaluated mid-cycle, decides what the coming edge does.
  initial begin
    bit m_full;
    int m_last;
    bit load;
    bit gv;
    int g;
    int c;
    logic [N-1:0] exp_ready;
    m_full = 0;
    m_last = N - 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_full = 0;
        m_last = N - 1;
        sb.delete();
      end else begin
        load = !m_full || out_ready;
        gv = 0;
        g  = 0;
        if (mode == 1'b0) begin
          if (int'(sel) < N) begin
            if (in_valid[sel]) begin
              gv = 1;
              g  = int'(sel);
            end
          end
        end else begin
          for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (!gv && in_valid[c]) begin
              gv = 1;
              g  = c;
            end
          end
        end
        exp_ready = (load && gv) ? N'(1 << g) : '0;
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("out_valid", 64'(out_valid), 64'(m_full));
        if (load) begin
          if (gv) begin
            sb.push_back({SW'(g), in_data[g*W +: W]});
            m_full = 1;
            m_last = g;
          end else begin
            m_full = 0;
          end
        end
      end
    end
  end

  // Monitor: every beat the consumer takes must be the oldest expected one.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=beat ch%0d expected=no beat", out_ch);
        end else begin
          b = sb.pop_front();
          chk("sb_out_ch", 64'(out_ch), 64'(b.ch));
          chk("sb_out_data", 64'(out_data), 64'(b.data));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // Round-robin, all channels valid: 0..6 twice.
    set_ramp_data();
    mode      = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      step();
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_ch", 64'(out_ch), 64'(i % N));
      chk("rr_data", 64'(out_data), 64'((i % N) + 8'h10));
    end

    // Round-robin with holes: ch0, ch2, ch6 only, wrapping.
    in_valid = 7'b1000101;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_sparse_ch", 64'(out_ch), 64'((i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 6));
    end

    // Fixed select on ch3.
    mode     = 1'b0;
    sel      = 3'd3;
    in_valid = 7'h08;
    in_data[3*W +: W] = 8'hA5;
    #1;
    chk("fix_in_ready", 64'(in_ready), 64'h08);
    step();
    chk("fix_valid", 64'(out_valid), 64'd1);
    chk("fix_data", 64'(out_data), 64'hA5);
    chk("fix_ch", 64'(out_ch), 64'd3);

    // Out-of-range select never grants.
    sel      = 3'd7;
    in_valid = '1;
    #1;
    chk("oor_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("oor_out_valid", 64'(out_valid), 64'd0);
      chk("oor_in_ready_cyc", 64'(in_ready), 64'd0);
    end

    // Backpressure holds the beat and blocks all inputs.
    set_ramp_data();
    sel = 3'd2;
    step();
    chk("bp_load_ch", 64'(out_ch), 64'd2);
    held = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ch", 64'(out_ch), 64'd2);
      chk("bp_data", 64'(out_data), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    sel       = 3'd5;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h20);
    step();
    chk("bp_next_ch", 64'(out_ch), 64'd5);
    chk("bp_next_data", 64'(out_data), 64'h15);
    chk("bp_next_valid", 64'(out_valid), 64'd1);

    // Asynchronous reset while a beat is held.
    mode      = 1'b1;
    out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_ch", 64'(out_ch), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_ch", 64'(out_ch), 64'd0);
    chk("post_rst_valid", 64'(out_valid), 64'd1);

    // Randomized traffic, checked by the model and scoreboard.
    for (int i = 0; i < 600; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, 7));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_n_to_1.md
# stream_mux_n_to_1

Parametrised N-to-1 streaming multiplexer with per-channel valid/ready handshake and a registered output stage. It generalises the team's fixed 7:1 combinational mux to arbitrary channel count and data width. It adds two selection modes, fixed-select and round-robin, and full backpressure. It sits between N producer channels and a single downstream consumer.

## Interface
- N, default 7: number of input channels, 2..64.
- W, default 8: data width per channel, 1..64.
- SW (localparam) = clog2(N): width of the select input and the channel-index output.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronised externally.
- mode  input  1  selection mode. 0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used when mode=0.
- in_data  input  N*W  channel data, flat; channel k occupies bits [k*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready. At most one bit is high in any cycle.
- out_data  output  W  registered output data.
- out_ch  output  SW  index of the channel that produced out_data.
- out_valid  output  1  output valid.
- out_ready  input  1  downstream ready.

## Operation
- Output register state is {out_valid, out_data, out_ch}.
- load_en = !out_valid || out_ready. The register is empty, or it is being drained this cycle.
- Grant selection (combinational, same cycle):
  - mode=0: grant = sel if sel < N and in_valid[sel]. Otherwise there is no grant.
  - Out-of-range sel (sel >= N) never grants and never raises any in_ready. This generalises the tied-zero unused input of the fixed mux.
  - mode=1: grant = the first k with in_valid[k]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N, wrapping past N-1 to 0. If no input is valid, there is no grant.
- in_ready[k] = load_en && grant_valid && (k == grant). All other in_ready bits are 0.
- Transfer on channel k occurs when in_valid[k] && in_ready[k]. At the next rising edge:
  - out_data <= channel k data.
  - out_ch <= k.
  - out_valid <= 1.
- If load_en=1 and there is no grant, out_valid <= 0. out_data and out_ch hold their values.
- If load_en=0, the register holds all of its values.
- rr_ptr (SW bits, internal) <= k on every transfer, in both modes.
  - rr_ptr therefore tracks the last served channel.
  - Switching from mode 0 to mode 1 continues the rotation from the last served channel.
- Mode and sel may change on any cycle. The new value takes effect in the same cycle's grant decision.
- Data is never duplicated or dropped: each input beat transfers exactly once.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=N-1, in_ready=0 (in_ready is combinational and is 0 while out_valid=0 with no valid inputs).
- First round-robin grant after reset goes to channel 0 if it is valid.
- Latency: 1 cycle from input transfer to out_valid=1 carrying that data.
- Throughput: 1 beat per cycle while out_ready is held at 1.
- Backpressure: when out_valid=1 and out_ready=0, all in_ready bits are 0 in that cycle.
- Simultaneous drain and load: out_valid=1 and out_ready=1 with a grant.
  - The old beat is consumed and the new beat is loaded in the same edge.
  - out_valid stays 1.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for a clock edge. Any held beat is discarded.
- Round-robin fairness: with all N inputs continuously valid and out_ready=1, each channel is served exactly once in every N consecutive transfers.

## Test plan
- Reset, then N=7, W=8, mode=0, sel=3, in_valid=7'h08, in_data ch3=8'hA5, out_ready=1:
  - in_ready=7'h08.
  - Next cycle out_valid=1, out_data=8'hA5, out_ch=3.
- mode=0, sel=7 (out of range), all in_valid=1:
  - in_ready=0 every cycle.
  - out_valid falls to 0 one cycle after the last held beat drains.
- mode=1, all 7 inputs valid, ch k data = k+8'h10, out_ready=1 for 14 cycles:
  - out_ch sequence is 0,1,2,3,4,5,6,0,1,...
  - out_data = out_ch+8'h10.
- mode=1, in_valid=7'b1000101 (ch0, ch2, ch6 valid), out_ready=1:
  - out_ch sequence is 0,2,6,0,2,6, showing wrap-around with skipped channels.
- Backpressure: load one beat, then drop out_ready for 3 cycles.
  - out_valid, out_data and out_ch stay stable.
  - in_ready=0 throughout.
  - On the cycle out_ready returns to 1, the next beat loads with no gap.
- Assert rst_n=0 mid-stream while out_valid=1:
  - out_valid=0 immediately, without waiting for a clock edge.
  - After release in mode=1 with all inputs valid, the first out_ch=0.
